// File: rtl/ntt_stage_scheduler.sv
// rtl/ntt_stage_scheduler.sv - stage/butterfly sequencer for an in-place Cooley-Tukey NTT
// Issues read/twiddle addresses per butterfly and replays them as write-backs LAT cycles later.
module ntt_stage_scheduler #(
  parameter int LOG_N      = 10,
  parameter int RD_LATENCY = 1,
  parameter int BF_LATENCY = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG_N-1:0] stage,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-1:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);

  localparam int LAT = RD_LATENCY + BF_LATENCY;
  localparam logic [LOG_N-1:0] K_LAST = LOG_N'((1 << (LOG_N - 1)) - 1);
  localparam logic [LOG_N-1:0] S_LAST = LOG_N'(LOG_N - 1);
  localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE_ST} state_t;

  state_t           state, state_nxt;
  logic [LOG_N-1:0] k, k_nxt, stage_nxt;
  logic             pending;
  logic             issue_nxt;
  logic [LOG_N-1:0] shamt, len, i_idx, j_idx, addr_a, addr_b, tw;
  logic [LAT-1:0]   en_pipe;
  logic [LOG_N-1:0] a_pipe [LAT];
  logic [LOG_N-1:0] b_pipe [LAT];

  // The entry currently at the pipe output is being written this cycle, so it does not block.
  always_comb begin
    pending = rd_en;
    for (int n = 0; n < LAT - 1; n++) pending = pending | en_pipe[n];
  end

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    k_nxt     = k;
    case (state)
      IDLE, DONE_ST: begin
        state_nxt = IDLE;
        if (start) begin
          state_nxt = ISSUE;
          stage_nxt = '0;
          k_nxt     = '0;
        end
      end
      ISSUE: begin
        if (k == K_LAST) state_nxt = DRAIN;
        else             k_nxt     = k + ONE;
      end
      DRAIN: begin
        if (!pending) begin
          if (stage == S_LAST) begin
            state_nxt = DONE_ST;
          end else begin
            state_nxt = ISSUE;
            stage_nxt = stage + ONE;
            k_nxt     = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered alongside the state, so addresses derive from the next stage/k.
  always_comb begin
    issue_nxt = (state_nxt == ISSUE);
    shamt     = S_LAST - stage_nxt;
    len       = ONE << shamt;
    i_idx     = k_nxt >> shamt;
    j_idx     = k_nxt & (len - ONE);
    addr_a    = (i_idx << (shamt + ONE)) | j_idx;
    addr_b    = addr_a + len;
    tw        = (ONE << stage_nxt) + i_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage     <= '0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      en_pipe   <= '0;
      for (int n = 0; n < LAT; n++) begin
        a_pipe[n] <= '0;
        b_pipe[n] <= '0;
      end
    end else begin
      state     <= state_nxt;
      stage     <= stage_nxt;
      k         <= k_nxt;
      busy      <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
      done      <= (state_nxt == DONE_ST);
      rd_en     <= issue_nxt;
      rd_addr_a <= issue_nxt ? addr_a : '0;
      rd_addr_b <= issue_nxt ? addr_b : '0;
      tw_addr   <= issue_nxt ? tw : '0;
      en_pipe[0] <= rd_en;
      a_pipe[0]  <= rd_addr_a;
      b_pipe[0]  <= rd_addr_b;
      for (int n = 1; n < LAT; n++) begin
        en_pipe[n] <= en_pipe[n-1];
        a_pipe[n]  <= a_pipe[n-1];
        b_pipe[n]  <= b_pipe[n-1];
      end
    end
  end

  assign wr_en     = en_pipe[LAT-1];
  assign wr_addr_a = a_pipe[LAT-1];
  assign wr_addr_b = b_pipe[LAT-1];

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// tb/tb_ntt_stage_scheduler.sv - directed-vector bench for ntt_stage_scheduler
// LOG_N=3, LAT=3; cycle c is sampled 1 time unit after the c-th edge following start.
module tb_ntt_stage_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

  int vectors = 0;
  int miscompares = 0;

  logic       e_rd [32];
  logic       e_wr [32];
  logic       e_busy [32];
  logic       e_done [32];
  logic [2:0] e_a [32];
  logic [2:0] e_b [32];
  logic [2:0] e_tw [32];
  logic [2:0] e_st [32];
  logic [2:0] e_wa [32];
  logic [2:0] e_wb [32];

  ntt_stage_scheduler #(.LOG_N(3), .RD_LATENCY(1), .BF_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  // Hand-computed pair tables: stage s reads at cycles 1+7s..4+7s, writes 3 cycles later.
  task automatic build_expected();
    logic [2:0] ta [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd2, 3'd4, 3'd6};
    logic [2:0] tb [12] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd1, 3'd3, 3'd5, 3'd7};
    logic [2:0] tt [12] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int c = 0; c < 32; c++) begin
      e_rd[c] = 1'b0; e_wr[c] = 1'b0; e_a[c] = '0; e_b[c] = '0; e_tw[c] = '0;
      e_st[c] = '0; e_wa[c] = '0; e_wb[c] = '0;
      e_busy[c] = (c >= 1 && c <= 21);
      e_done[c] = (c == 22);
    end
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = 1 + 7 * s + k;
        e_rd[c] = 1'b1; e_a[c] = ta[4*s+k]; e_b[c] = tb[4*s+k]; e_tw[c] = tt[4*s+k];
        e_st[c] = 3'(s);
        e_wr[c+3] = 1'b1; e_wa[c+3] = ta[4*s+k]; e_wb[c+3] = tb[4*s+k];
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    vectors++;
    if ({busy, done, rd_en, wr_en} !== 4'b0) begin
      miscompares++; $display("FAIL reset_strobes got %b want 0000", {busy, done, rd_en, wr_en});
    end
    vectors++;
    if ({stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 18'd0) begin
      miscompares++; $display("FAIL reset_addrs got %h want 0", {stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_transform();
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      start = (c == 10);
      vectors++;
      if (rd_en !== e_rd[c]) begin miscompares++; $display("FAIL rd_en c%0d got %b want %b", c, rd_en, e_rd[c]); end
      vectors++;
      if (wr_en !== e_wr[c]) begin miscompares++; $display("FAIL wr_en c%0d got %b want %b", c, wr_en, e_wr[c]); end
      vectors++;
      if (busy !== e_busy[c]) begin miscompares++; $display("FAIL busy c%0d got %b want %b", c, busy, e_busy[c]); end
      vectors++;
      if (done !== e_done[c]) begin miscompares++; $display("FAIL done c%0d got %b want %b", c, done, e_done[c]); end
      if (e_rd[c]) begin
        vectors++;
        if ({rd_addr_a, rd_addr_b, tw_addr, stage} !== {e_a[c], e_b[c], e_tw[c], e_st[c]})
          begin miscompares++; $display("FAIL rd_pair c%0d got a%0d b%0d tw%0d s%0d want a%0d b%0d tw%0d s%0d",
            c, rd_addr_a, rd_addr_b, tw_addr, stage, e_a[c], e_b[c], e_tw[c], e_st[c]); end
      end
      if (e_wr[c]) begin
        vectors++;
        if ({wr_addr_a, wr_addr_b} !== {e_wa[c], e_wb[c]})
          begin miscompares++; $display("FAIL wr_pair c%0d got a%0d b%0d want a%0d b%0d",
            c, wr_addr_a, wr_addr_b, e_wa[c], e_wb[c]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    vectors++;
    if ({wr_en, busy} !== 2'b11) begin miscompares++; $display("FAIL mid_pre c12 got %b want 11", {wr_en, busy}); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, rd_en, wr_en} !== 4'b0) begin
      miscompares++; $display("FAIL mid_reset_strobes got %b want 0000", {busy, done, rd_en, wr_en});
    end
    vectors++;
    if ({stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 18'd0) begin
      miscompares++; $display("FAIL mid_reset_addrs got %h want 0", {stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL mid_no_done got activity want quiet"); end
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      vectors++;
      if (rd_en !== e_rd[c]) begin miscompares++; $display("FAIL restart_rd_en c%0d got %b want %b", c, rd_en, e_rd[c]); end
      if (e_rd[c]) begin
        vectors++;
        if ({rd_addr_a, rd_addr_b, tw_addr, stage} !== {e_a[c], e_b[c], e_tw[c], e_st[c]})
          begin miscompares++; $display("FAIL restart_pair c%0d got a%0d b%0d tw%0d want a%0d b%0d tw%0d",
            c, rd_addr_a, rd_addr_b, tw_addr, e_a[c], e_b[c], e_tw[c]); end
      end
    end
    for (int c = 0; c < 30; c++) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL restart_idle got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic seen;
    start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      int x;
      @(posedge clk); #1;
      x = (c <= 22) ? c : c - 22;
      vectors++;
      if (rd_en !== e_rd[x]) begin miscompares++; $display("FAIL b2b_rd_en c%0d got %b want %b", c, rd_en, e_rd[x]); end
      vectors++;
      if (done !== e_done[x]) begin miscompares++; $display("FAIL b2b_done c%0d got %b want %b", c, done, e_done[x]); end
      if (e_rd[x]) begin
        vectors++;
        if ({rd_addr_a, rd_addr_b, tw_addr} !== {e_a[x], e_b[x], e_tw[x]})
          begin miscompares++; $display("FAIL b2b_pair c%0d got a%0d b%0d tw%0d want a%0d b%0d tw%0d",
            c, rd_addr_a, rd_addr_b, tw_addr, e_a[x], e_b[x], e_tw[x]); end
      end
    end
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL b2b_second_done got none want pulse within 40 cycles"); end
    @(posedge clk); #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL b2b_idle got %b want 00", {busy, done}); end
  endtask

  initial begin
    build_expected();
    test_reset();
    test_full_transform();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
